updn_mod_counter: RTL and testbench

UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

---
 rtl/updn_mod_counter.sv | 130 +++++++++++++
 tb/tb_updn_mod_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/updn_mod_counter.sv
// -----------------------------------------------------------------------------
// updn_mod_counter
//
// Up/down counter over the range 0..MAX_VAL. By default it wraps modulo
// MAX_VAL+1. On every wrap it raises a one-cycle tc pulse and bumps a
// saturating 8-bit wrap counter.
//
// Optional feature (compile-time macro):
//   UPDN_MOD_COUNTER_SAT_EN
//     When defined, the counter clamps at the ends of its range instead of
//     wrapping. tc pulses on the first clamped step only. wrap_cnt never
//     increments in this mode.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  terminal value (1..2**WIDTH-1), default all ones
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable
//   up_dn     direction: 1 = up, 0 = down
//   clr       synchronous clear (highest priority)
//   load      synchronous load of min(load_val, MAX_VAL)
//   load_val  value to load
//   cnt       registered count
//   tc        registered terminal-count event pulse
//   wrap_cnt  registered wrap-event count, saturating at 255
// -----------------------------------------------------------------------------
module updn_mod_counter #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic [7:0]       wrap_cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic             at_max;
    logic             at_zero;
    logic             at_boundary;

`ifdef UPDN_MOD_COUNTER_SAT_EN
    // Set while the counter sits clamped at an end. This makes tc fire
    // only on the first clamped step and not on the repeated held steps.
    logic             clamp_q, clamp_d;
`endif

    assign at_max  = (cnt_q == MAX_VAL);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d       = cnt_q;
        tc_d        = 1'b0;
        wrap_cnt_d  = wrap_cnt_q;
        at_boundary = up_dn ? at_max : at_zero;
`ifdef UPDN_MOD_COUNTER_SAT_EN
        clamp_d     = clamp_q;
`endif

        if (clr) begin
            cnt_d      = '0;
            wrap_cnt_d = '0;
`ifdef UPDN_MOD_COUNTER_SAT_EN
            clamp_d    = 1'b0;
`endif
        end else if (load) begin
            // Loads above the terminal value are clamped into range.
            cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
`ifdef UPDN_MOD_COUNTER_SAT_EN
            clamp_d = 1'b0;
`endif
        end else if (en) begin
            if (!at_boundary) begin
                cnt_d = up_dn ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
            end else begin
`ifdef UPDN_MOD_COUNTER_SAT_EN
                // Hold at the end. Pulse tc only on entry into the clamp.
                tc_d = ~clamp_q;
`else
                cnt_d = up_dn ? '0 : MAX_VAL;
                tc_d  = 1'b1;
                if (wrap_cnt_q != 8'hFF) begin
                    wrap_cnt_d = wrap_cnt_q + 8'd1;
                end
`endif
            end
`ifdef UPDN_MOD_COUNTER_SAT_EN
            clamp_d = at_boundary;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tc_q       <= 1'b0;
            wrap_cnt_q <= '0;
`ifdef UPDN_MOD_COUNTER_SAT_EN
            clamp_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values regardless of statement order.
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            wrap_cnt_q <= wrap_cnt_d;
`ifdef UPDN_MOD_COUNTER_SAT_EN
            clamp_q    <= clamp_d;
`endif
        end
    end

    assign cnt      = cnt_q;
    assign tc       = tc_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_updn_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updn_mod_counter
//
// Scoreboard bench for updn_mod_counter with WIDTH=4 and MAX_VAL=9.
// The driver applies one vector per cycle on the falling edge and pushes the
// hand-computed response expected after the next rising edge. A monitor
// process pops and compares shortly after every rising edge.
// The async-reset checks are made directly, between clock edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updn_mod_counter;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] cnt;
        logic         tc;
        logic [7:0]   wrap;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         tc;
    logic [7:0]   wrap_cnt;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    updn_mod_counter #(
        .WIDTH   (W),
        .MAX_VAL (4'd9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .tc       (tc),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the response expected after the next edge.
    task automatic step(input logic i_en, input logic i_up, input logic i_clr,
                        input logic i_load, input logic [W-1:0] i_lv,
                        input logic [W-1:0] e_cnt, input logic e_tc,
                        input logic [7:0] e_wrap, input string name);
        exp_t e;
        @(negedge clk);
        en       = i_en;
        up_dn    = i_up;
        clr      = i_clr;
        load     = i_load;
        load_val = i_lv;
        e.cnt  = e_cnt;
        e.tc   = e_tc;
        e.wrap = e_wrap;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Pulse rst_n low between clock edges and check the outputs before any
    // further edge arrives.
    task automatic async_reset_pulse();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt), 32'd0);
        check("async_rst_tc", 32'(tc), 32'd0);
        check("async_rst_wrap", 32'(wrap_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: the counter presents a new response after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_cnt"}, 32'(cnt), 32'(e.cnt));
                check({e.name, "_tc"}, 32'(tc), 32'(e.tc));
                check({e.name, "_wrap"}, 32'(wrap_cnt), 32'(e.wrap));
            end
        end
    end

    // Watchdog bounds the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        rst_n    = 1'b0;
        en       = 1'b1;
        up_dn    = 1'b1;
        clr      = 1'b0;
        load     = 1'b1;
        load_val = 4'd5;

        // Reset held with clk running and load/en active: all must stay 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_tc", 32'(tc), 32'd0);
        check("rst_wrap", 32'(wrap_cnt), 32'd0);
        en    = 1'b0;
        load  = 1'b0;
        rst_n = 1'b1;

`ifdef UPDN_MOD_COUNTER_SAT_EN
        // Count up 12 edges: clamp at 9, tc on the first clamp only.
        for (int i = 1; i <= 9; i++) step(1, 1, 0, 0, 0, 4'(i), 0, 0, "sat_up");
        step(1, 1, 0, 0, 0, 9, 1, 0, "sat_up_clamp");
        step(1, 1, 0, 0, 0, 9, 0, 0, "sat_up_hold1");
        step(1, 1, 0, 0, 0, 9, 0, 0, "sat_up_hold2");
        // Count down to 0 and clamp there.
        for (int i = 8; i >= 0; i--) step(1, 0, 0, 0, 0, 4'(i), 0, 0, "sat_dn");
        step(1, 0, 0, 0, 0, 0, 1, 0, "sat_dn_clamp");
        step(1, 0, 0, 0, 0, 0, 0, 0, "sat_dn_hold");
        // A load ends the clamp, so the next clamped step pulses again.
        step(0, 1, 0, 1, 4'hF, 9, 0, 0, "sat_load_clamp");
        step(1, 1, 0, 0, 0, 9, 1, 0, "sat_reclamp");
        step(1, 1, 1, 1, 5, 0, 0, 0, "sat_clr_prio");
        step(0, 1, 0, 1, 6, 6, 0, 0, "sat_load6");
        async_reset_pulse();
        step(1, 1, 0, 0, 0, 1, 0, 0, "sat_first_step");
`else
        // Up 10 edges: 1..9 then wrap to 0 with tc.
        for (int i = 1; i <= 9; i++) step(1, 1, 0, 0, 0, 4'(i), 0, 0, "up");
        step(1, 1, 0, 0, 0, 0, 1, 1, "up_wrap");
        step(0, 1, 0, 0, 0, 0, 0, 1, "hold");

        // Clamped load, then down 12 edges through a down wrap.
        step(0, 0, 0, 1, 4'hF, 9, 0, 1, "load_clamp");
        for (int i = 8; i >= 0; i--) step(1, 0, 0, 0, 0, 4'(i), 0, 1, "down");
        step(1, 0, 0, 0, 0, 9, 1, 2, "down_wrap");
        step(1, 0, 0, 0, 0, 8, 0, 2, "down_after1");
        step(1, 0, 0, 0, 0, 7, 0, 2, "down_after2");

        // Load beats a pending up wrap.
        step(0, 1, 0, 1, 9, 9, 0, 2, "load9");
        step(1, 1, 0, 1, 3, 3, 0, 2, "load_over_wrap");

        // Direction changes on consecutive cycles.
        step(1, 1, 0, 0, 0, 4, 0, 2, "dir_up");
        step(1, 0, 0, 0, 0, 3, 0, 2, "dir_dn");
        step(1, 1, 0, 0, 0, 4, 0, 2, "dir_up2");

        // Clear beats load and en, and clears wrap_cnt.
        step(1, 1, 1, 1, 5, 0, 0, 0, "clr_prio");
        step(1, 1, 0, 1, 5, 5, 0, 0, "load_after_clr");

        // Clear suppresses a pending down wrap.
        step(0, 0, 0, 1, 0, 0, 0, 0, "load0");
        step(1, 0, 1, 0, 0, 0, 0, 0, "clr_over_wrap");
        step(1, 0, 0, 0, 0, 9, 1, 1, "down_wrap2");

        // Drive wrap_cnt into saturation with load/wrap pairs.
        w = 8'd1;
        for (int k = 0; k < 260; k++) begin
            step(0, 1, 0, 1, 9, 9, 0, w, "sat_load");
            w = (w == 8'hFF) ? 8'hFF : w + 8'd1;
            step(1, 1, 0, 0, 0, 0, 1, w, "sat_wrap");
        end
        step(0, 1, 1, 0, 0, 0, 0, 0, "clr_wrapcnt");

        // Async reset mid-count.
        step(1, 0, 0, 0, 0, 9, 1, 1, "pre_rst_wrap");
        step(0, 1, 0, 1, 6, 6, 0, 1, "load6");
        async_reset_pulse();
        step(0, 1, 0, 0, 0, 0, 0, 0, "post_rst_hold");
        step(1, 1, 0, 0, 0, 1, 0, 0, "post_rst_step");
`endif

        // Let the monitor drain the scoreboard, within a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
